// File: rtl/bdpsk_pkg.sv
// Shared constants and types for the BDPSK encoder/decoder pair.
// Holds the PN7 definition, the checker state encoding and the sample zero level.
package bdpsk_pkg;

    localparam int               PN_W        = 7;
    localparam logic [PN_W-1:0]  PN_TAPS     = 7'b110_0000;   // x^7 + x^6 + 1
    localparam logic [7:0]       ZERO_LEVEL  = 8'h80;
    localparam int               DEFAULT_SPS = 16;

    typedef enum logic [1:0] {
        ST_SEED,
        ST_TRACK,
        ST_LOCKED
    } pn_state_t;

    // Next PN bit predicted from the last PN_W bits (bit 0 = newest).
    function automatic logic pn_predict(input logic [PN_W-1:0] lfsr);
        return ^(lfsr & PN_TAPS);
    endfunction

endpackage

// File: rtl/bdpsk_pn_checker.sv
// PN7 checker: seeds from the received bits, tracks until LOCK_CNT matches,
// then free-runs and counts errors; UNLOCK_CNT consecutive misses drop lock.
module bdpsk_pn_checker
    import bdpsk_pkg::*;
#(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_bit,
    input  logic        i_valid,
    output logic        o_lock,
    output logic [15:0] o_err_count
);

    localparam int SEED_W  = $clog2(PN_W);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

    pn_state_t          r_state,     w_state_next;
    logic [PN_W-1:0]    r_lfsr,      w_lfsr_next;
    logic [SEED_W-1:0]  r_seed_cnt,  w_seed_next;
    logic [MATCH_W-1:0] r_match_cnt, w_match_next;
    logic [MISS_W-1:0]  r_miss_cnt,  w_miss_next;
    logic [15:0]        r_err_count, w_err_next;
    logic               w_pred;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_SEED;
            r_lfsr      <= '0;
            r_seed_cnt  <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_err_count <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state     <= w_state_next;
            r_lfsr      <= w_lfsr_next;
            r_seed_cnt  <= w_seed_next;
            r_match_cnt <= w_match_next;
            r_miss_cnt  <= w_miss_next;
            r_err_count <= w_err_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
        w_state_next = r_state;
        w_lfsr_next  = r_lfsr;
        w_seed_next  = r_seed_cnt;
        w_match_next = r_match_cnt;
        w_miss_next  = r_miss_cnt;
        w_err_next   = r_err_count;
        w_pred       = pn_predict(r_lfsr);

        if (i_valid) begin
            unique case (r_state)
                ST_SEED: begin
                    w_lfsr_next = {r_lfsr[PN_W-2:0], i_bit};
                    if (r_seed_cnt == SEED_W'(PN_W - 1)) begin
                        w_seed_next  = '0;
                        w_match_next = '0;
                        w_state_next = ST_TRACK;
                    end else begin
                        w_seed_next = r_seed_cnt + SEED_W'(1);
                    end
                end
                ST_TRACK: begin
                    if (i_bit == w_pred) begin
                        w_lfsr_next = {r_lfsr[PN_W-2:0], i_bit};
                        if (r_match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                            w_match_next = '0;
                            w_miss_next  = '0;
                            w_state_next = ST_LOCKED;
                        end else begin
                            w_match_next = r_match_cnt + MATCH_W'(1);
                        end
                    end else begin
                        w_seed_next  = '0;
                        w_match_next = '0;
                        w_state_next = ST_SEED;
                    end
                end
                ST_LOCKED: begin
                    // Received bits are only compared here; the LFSR follows its own prediction.
                    w_lfsr_next = {r_lfsr[PN_W-2:0], w_pred};
                    if (i_bit != w_pred) begin
                        if (r_err_count != 16'hFFFF) w_err_next = r_err_count + 16'd1;
                        if (r_miss_cnt == MISS_W'(UNLOCK_CNT - 1)) begin
                            w_miss_next  = '0;
                            w_seed_next  = '0;
                            w_state_next = ST_SEED;
                        end else begin
                            w_miss_next = r_miss_cnt + MISS_W'(1);
                        end
                    end else begin
                        w_miss_next = '0;
                    end
                end
                default: w_state_next = ST_SEED;
            endcase
        end
    end

    assign o_lock      = (r_state == ST_LOCKED);
    assign o_err_count = r_err_count;

endmodule

// File: rtl/bdpsk_decoder.sv
// BDPSK receiver: delay-and-multiply against the previous symbol, integrate
// over the symbol, decide on the sign, and feed the bits to a PN7 checker.
module bdpsk_decoder
    import bdpsk_pkg::*;
#(
    parameter int SPS        = DEFAULT_SPS,
    parameter int ACC_W      = 20,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        sym_strobe,
    output logic        data_out,
    output logic        data_valid,
    output logic        pn_lock,
    output logic [15:0] err_count
);

    localparam int CNT_W = $clog2(SPS);

    logic [7:0]        r_dline [SPS];
    logic [CNT_W-1:0]  r_wptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ref_valid;

    logic signed [15:0] r_p;
    logic               r_p_valid;
    logic               r_p_first;
    logic               r_p_last;
    logic               r_p_emit;

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_data_out;
    logic                    r_data_valid;

    logic signed [7:0]       w_s;
    logic signed [7:0]       w_d;
    logic signed [15:0]      w_prod;
    logic [CNT_W-1:0]        w_cnt;
    logic                    w_first;
    logic                    w_last;
    logic                    w_realign;
    logic signed [ACC_W-1:0] w_p_ext;
    logic signed [ACC_W-1:0] w_acc_next;
    logic                    w_emit;

    assign w_s       = signed'(din ^ ZERO_LEVEL);
    assign w_d       = signed'(r_dline[r_wptr]);
    assign w_prod    = 16'(w_s) * 16'(w_d);
    assign w_cnt     = sym_strobe ? '0 : r_cnt;
    assign w_first   = (w_cnt == '0);
    assign w_last    = (w_cnt == CNT_W'(SPS - 1));
    assign w_realign = sym_strobe && (r_cnt != '0);

    // Input stage: the delay line is written at the same slot it is read from,
    // so the read value is always exactly SPS accepted samples old.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the delay line is reset because the reference symbol is defined against a cleared history.
            for (int i = 0; i < SPS; i++) r_dline[i] <= '0;
            r_wptr      <= '0;
            r_cnt       <= '0;
            r_ref_valid <= 1'b0;
            r_p         <= '0;
            r_p_valid   <= 1'b0;
            r_p_first   <= 1'b0;
            r_p_last    <= 1'b0;
            r_p_emit    <= 1'b0;
        end else begin
            r_p_valid <= din_valid;
            if (din_valid) begin
                r_dline[r_wptr] <= w_s;
                r_wptr          <= r_wptr + CNT_W'(1);
                r_cnt           <= w_cnt + CNT_W'(1);
                r_p             <= w_prod;
                r_p_first       <= w_first;
                r_p_last        <= w_last;
                r_p_emit        <= w_last && r_ref_valid;
                if (w_realign)   r_ref_valid <= 1'b0;
                else if (w_last) r_ref_valid <= 1'b1;
            end
        end
    end

    assign w_p_ext    = {{(ACC_W - 16){r_p[15]}}, r_p};
    assign w_acc_next = r_p_first ? w_p_ext : (r_acc + w_p_ext);
    assign w_emit     = r_p_valid && r_p_last && r_p_emit;

    // Integrate and decide in the same stage so the decision uses the final sum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc        <= '0;
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_emit;
            if (r_p_valid) r_acc <= w_acc_next;
            if (w_emit)    r_data_out <= w_acc_next[ACC_W-1];
        end
    end

    bdpsk_pn_checker #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_pn_checker (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_bit       (r_data_out),
        .i_valid     (r_data_valid),
        .o_lock      (pn_lock),
        .o_err_count (err_count)
    );

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

endmodule

// File: tb/tb_bdpsk_decoder.sv
// Self-checking bench for bdpsk_decoder: decisions and their latency go through
// a scoreboard queue; lock and error-count behaviour is checked at fixed points.
module tb_bdpsk_decoder;

    localparam int SPS = 16;

    typedef struct {
        logic        bit_v;
        int unsigned due;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        sym_strobe;
    logic        data_out;
    logic        data_valid;
    logic        pn_lock;
    logic [15:0] err_count;

    int unsigned n_cmp;
    int unsigned n_fail;
    int unsigned cyc;
    exp_t        sb_q[$];

    int          m_cnt;
    bit          m_ref;
    int          prev_amp;
    int          enc_amp;
    logic [6:0]  pn_st;
    int          wv[4] = '{0, 100, 0, -100};

    bdpsk_decoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .sym_strobe (sym_strobe),
        .data_out   (data_out),
        .data_valid (data_valid),
        .pn_lock    (pn_lock),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && data_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_data_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("data_out", {31'd0, data_out}, {31'd0, e.bit_v});
                check("latency_cycle", cyc, e.due);
            end
        end
    end

    task automatic drive_sample(input logic [7:0] v, input logic strobe, input logic exp_bit);
        @(posedge clk);
        #1;
        din        = v;
        din_valid  = 1'b1;
        sym_strobe = strobe;
        if (strobe && m_cnt != 0) m_ref = 1'b0;
        if (strobe) m_cnt = 0;
        if (m_cnt == SPS - 1) begin
            if (m_ref) sb_q.push_back('{bit_v: exp_bit, due: cyc + 2});
            m_ref = 1'b1;
        end
        m_cnt = (m_cnt + 1) % SPS;
    endtask

    task automatic drive_idle();
        @(posedge clk);
        #1;
        din        = 8'h80;
        din_valid  = 1'b0;
        sym_strobe = 1'b0;
    endtask

    // amp is +1, -1 or 0; the expected decision is a phase reversal against the previous symbol.
    task automatic drive_symbol(input int amp, input int n_samp, input bit gaps);
        logic       exp_bit;
        logic [7:0] v;
        int         s;
        exp_bit = (amp * prev_amp) < 0;
        for (int i = 0; i < n_samp; i++) begin
            s = amp * wv[i % 4];
            v = s[7:0] ^ 8'h80;
            drive_sample(v, i == 0, exp_bit);
            if (gaps) drive_idle();
        end
        prev_amp = amp;
    endtask

    task automatic drain(input int n);
        repeat (n) drive_idle();
        check("pending_decisions", sb_q.size(), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        din_valid  = 1'b0;
        sym_strobe = 1'b0;
        din        = 8'h80;
        repeat (2) @(negedge clk);
        check("rst_data_out", {31'd0, data_out}, 32'd0);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_pn_lock", {31'd0, pn_lock}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        sb_q.delete();
        m_cnt    = 0;
        m_ref    = 1'b0;
        prev_amp = 0;
        reset_n  = 1'b1;
    endtask

    // One PN7 bit, differentially encoded; corrupt inverts the transmitted samples only.
    task automatic pn_symbol(input bit corrupt);
        logic b;
        b       = pn_st[6] ^ pn_st[5];
        pn_st   = {pn_st[5:0], b};
        enc_amp = b ? -enc_amp : enc_amp;
        drive_symbol(corrupt ? -enc_amp : enc_amp, SPS, 1'b0);
    endtask

    initial begin
        int amps_a[4] = '{1, 1, -1, 1};
        int amps_z[4] = '{1, -1, 0, -1};
        n_cmp      = 0;
        n_fail     = 0;
        cyc        = 0;
        reset_n    = 1'b0;
        din        = 8'h80;
        din_valid  = 1'b0;
        sym_strobe = 1'b0;

        // Constant phase: three zero decisions, first one 2 clocks after sample 31.
        apply_reset();
        for (int k = 0; k < 4; k++) drive_symbol(1, SPS, 1'b0);
        drain(6);

        // Phase inversions at symbols 2 and 3.
        apply_reset();
        for (int k = 0; k < 4; k++) drive_symbol(amps_a[k], SPS, 1'b0);
        drain(6);

        // Zero-level symbol, without and with gaps on din_valid.
        for (int g = 0; g < 2; g++) begin
            apply_reset();
            for (int k = 0; k < 4; k++) drive_symbol(amps_z[k], SPS, g == 1);
            drain(6);
        end

        // Realignment at count 5: partial and following reference symbol are silent.
        apply_reset();
        drive_symbol(1, SPS, 1'b0);
        drive_symbol(1, SPS, 1'b0);
        drive_symbol(-1, 5, 1'b0);
        drive_symbol(1, SPS, 1'b0);
        drive_symbol(-1, SPS, 1'b0);
        drain(6);

        // PN7 acquisition: lock exactly at the 23rd decision.
        apply_reset();
        pn_st   = 7'h7F;
        enc_amp = 1;
        drive_symbol(enc_amp, SPS, 1'b0);
        for (int k = 0; k < 22; k++) pn_symbol(1'b0);
        drain(4);
        check("lock_before_23", {31'd0, pn_lock}, 32'd0);
        pn_symbol(1'b0);
        drain(4);
        check("lock_at_23", {31'd0, pn_lock}, 32'd1);
        for (int k = 23; k < 200; k++) pn_symbol(1'b0);
        drain(4);
        check("lock_after_200", {31'd0, pn_lock}, 32'd1);
        check("err_after_200", {16'd0, err_count}, 32'd0);

        // One inverted symbol: two bit errors, lock held.
        pn_symbol(1'b1);
        for (int k = 0; k < 3; k++) pn_symbol(1'b0);
        drain(4);
        check("err_single_corrupt", {16'd0, err_count}, 32'd2);
        check("lock_single_corrupt", {31'd0, pn_lock}, 32'd1);

        // Four consecutive bad decisions drop lock; reacquire after exactly 23 clean bits.
        for (int k = 0; k < 5; k++) pn_symbol(1'b0);
        pn_symbol(1'b1);
        pn_symbol(1'b0);
        pn_symbol(1'b1);
        pn_symbol(1'b0);
        drain(4);
        check("lock_dropped", {31'd0, pn_lock}, 32'd0);
        check("err_after_drop", {16'd0, err_count}, 32'd6);
        for (int k = 0; k < 22; k++) pn_symbol(1'b0);
        drain(4);
        check("relock_before_23", {31'd0, pn_lock}, 32'd0);
        pn_symbol(1'b0);
        drain(4);
        check("relock_at_23", {31'd0, pn_lock}, 32'd1);
        check("err_retained", {16'd0, err_count}, 32'd6);

        // Asynchronous reset mid-symbol clears outputs without a clock edge.
        drive_symbol(-enc_amp, 5, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_data_out", {31'd0, data_out}, 32'd0);
        check("async_rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("async_rst_pn_lock", {31'd0, pn_lock}, 32'd0);
        check("async_rst_err_count", {16'd0, err_count}, 32'd0);
        din_valid  = 1'b0;
        sym_strobe = 1'b0;
        sb_q.delete();
        m_cnt    = 0;
        m_ref    = 1'b0;
        prev_amp = 0;
        @(negedge clk);
        reset_n = 1'b1;
        drive_symbol(1, SPS, 1'b0);
        drive_symbol(-1, SPS, 1'b0);
        drain(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bdpsk_decoder.md
Name: bdpsk_decoder

Overview:
Receive-side counterpart of the BDPSK encoder. It accepts the encoder's 8-bit modulated sample stream and recovers the differential bit stream by delay-and-multiply: each sample is multiplied by the sample one symbol earlier, and the products are integrated over the symbol. A built-in PN7 checker acquires lock on the recovered bits and counts bit errors. The block sits at the loop-back/receive end of the modem test chain.

Parameters:
SPS, 16, samples per symbol (power of 2, 4..64)
ACC_W, 20, accumulator width (>= 16 + log2(SPS))
LOCK_CNT, 16, consecutive PN matches after seeding required for lock
UNLOCK_CNT, 4, consecutive PN mismatches that drop lock

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
din  in  8  sample, offset-binary (0x80 = zero level)
din_valid  in  1  din is valid this cycle
sym_strobe  in  1  qualified by din_valid: marks the first sample of a symbol
data_out  out  1  recovered bit (1 = 180° phase change)
data_valid  out  1  one-cycle pulse, data_out valid
pn_lock  out  1  PN7 checker locked
err_count  out  16  saturating count of PN mismatches while locked

Behaviour:
- Reset: all outputs 0; sample counter 0; delay line cleared; ref_valid=0; LFSR 0; checker unlocked.
- Input conversion: s = din XOR 0x80, interpreted as signed 8-bit.
- Delay line: SPS x 8 circular buffer, advances only on din_valid. d = sample written SPS accepted samples ago.
- Stage 1 (registered): p = s*d, signed 16-bit.
- Stage 2: the accumulator adds p. At the first product of a symbol it loads p instead of adding. Sign-extend to ACC_W; no saturation needed at the default widths.
- Symbol counter: 0..SPS-1, counts accepted samples and wraps. sym_strobe & din_valid forces the count to 0 for that sample.
- Mid-symbol realignment: sym_strobe arriving at a count other than 0 discards the partial symbol (no data_valid) and clears ref_valid.
- ref_valid: set at the end of the first complete symbol after reset or realignment. That first symbol only fills the delay line and produces no output.
- Decision: at symbol end with ref_valid=1, data_out = (acc < 0). acc == 0 gives 0.
- Latency: data_valid pulses exactly 2 clocks after the cycle in which the symbol's last sample is accepted. data_out holds until the next decision.
- Gaps: din_valid low stalls all stages without loss. Stage enables follow din_valid through the pipe.
- PN checker (runs on each data_valid), polynomial x^7+x^6+1:
  - SEED state: shift 7 received bits into the LFSR, then go to TRACK.
  - TRACK state: compare each bit to the LFSR prediction.
    - Match: increment the match count.
    - Mismatch: reload SEED and clear the match count.
    - Match count reaching LOCK_CNT: pn_lock=1, go to LOCKED.
  - LOCKED state: the LFSR free-runs on its own prediction and ignores received bits.
    - Each mismatch increments err_count (saturates at 0xFFFF).
    - UNLOCK_CNT consecutive mismatches: pn_lock=0, go to SEED.
    - err_count retains its value across unlock; it clears only on reset.
- Simultaneous sym_strobe at count 0 is the normal case and does not count as a realignment.
- reset_n asserted mid-symbol: immediate return to reset state. After release, one full reference symbol is required again.

Decomposition:
- Shared package bdpsk_pkg:
  - PN7 polynomial taps and LFSR width.
  - Checker state enum (SEED, TRACK, LOCKED).
  - Offset-binary zero constant 0x80.
  - Default SPS. The encoder uses the same package.
- Sub-module: bdpsk_pn_checker (state machine, LFSR, lock/error counters), driven by data_out and data_valid.
- Datapath (delay line, multiply, integrate, decide) stays in the top module.

Test Plan:
- Constant-phase carrier, 4 samples/cycle, amplitude ±100, SPS=16, 4 symbols, sym_strobe on each first sample -> 3 data_valid pulses, all data_out=0. First pulse exactly 2 clocks after sample 31.
- Same carrier, phase inverted at symbols 2 and 3 -> data_out sequence 0,1,1.
- Direct from the encoder, 200 PN7 bits -> pn_lock=1 after 7+16=23 decisions (plus the reference symbol); err_count=0 at the end.
- Locked stream with one symbol's samples inverted -> err_count=2, pn_lock stays 1. Then 4 consecutive corrupted decisions -> pn_lock=0, reacquires within 23 bits.
- din=0x80 for a whole symbol -> acc=0, data_out=0. With din_valid toggling every other cycle, same decisions as the gap-free run.
- sym_strobe injected at count 5 -> no output for the partial symbol or for the next (reference) symbol. reset_n pulled low mid-symbol -> all outputs 0 immediately.
